// File: rtl/interp_pkg.sv
// Shared types and constants for the linear interpolator.
// State encoding, DAC offset and default interpolation factor.
package interp_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [7:0] DA_OFFSET = 8'h80;
    localparam int INTERP_LOG2_DEF = 2;

endpackage

// File: rtl/interp_mac.sv
// Combinational interpolation datapath.
// Computes y = x0 + floor((x1 - x0) * k / 2^INTERP_LOG2).
module interp_mac #(
    parameter int DATA_WIDTH  = 12,
    parameter int INTERP_LOG2 = 2
) (
    input  logic signed [DATA_WIDTH-1:0]  x0,
    input  logic signed [DATA_WIDTH-1:0]  x1,
    input  logic        [INTERP_LOG2-1:0] k,
    output logic signed [DATA_WIDTH-1:0]  y
);

    localparam int PW = DATA_WIDTH + 1 + INTERP_LOG2;

    logic signed [DATA_WIDTH:0] diff;
    logic signed [PW-1:0]       diff_ext;
    logic signed [PW-1:0]       k_ext;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       shifted;
    logic                       unused_hi;

    assign diff     = {x1[DATA_WIDTH-1], x1}
                    - {x0[DATA_WIDTH-1], x0};
    assign diff_ext = {{INTERP_LOG2{diff[DATA_WIDTH]}}, diff};
    assign k_ext    = {{(DATA_WIDTH+1){1'b0}}, k};
    assign prod     = diff_ext * k_ext;
    assign shifted  = prod >>> INTERP_LOG2;

    // The result lies between x0 and x1, so the low bits are exact.
    assign y         = x0 + shifted[DATA_WIDTH-1:0];
    assign unused_hi = ^shifted[PW-1:DATA_WIDTH];

endmodule

// File: rtl/lin_interpolation.sv
// Linear interpolator between an output FIFO and a DAC.
// Emits L = 2^INTERP_LOG2 samples per FIFO word, gap-free.
module lin_interpolation
    import interp_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int INTERP_LOG2 = INTERP_LOG2_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] fifo_dout,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    output logic signed [DATA_WIDTH-1:0] inter_data,
    output logic                         inter_valid,
    output logic        [7:0]            da_code,
    output logic                         underrun,
    input  logic                         underrun_clr
);

    state_t                   state;
    logic signed [DATA_WIDTH-1:0] x0;
    logic signed [DATA_WIDTH-1:0] x1;
    logic signed [DATA_WIDTH-1:0] x0_eff;
    logic signed [DATA_WIDTH-1:0] x1_eff;
    logic signed [DATA_WIDTH-1:0] y;
    logic signed [DATA_WIDTH-1:0] y_next;
    logic [INTERP_LOG2-1:0]   k;
    logic                     rd_pend;
    logic                     fill_one;
    logic                     k_last;
    logic                     under_set;

    assign k_last = (k == {INTERP_LOG2{1'b1}});

    assign fifo_rd_en = !fifo_empty && !rd_pend
                     && (state == FILL || state == STALL
                         || (state == RUN && k_last));

    assign under_set = (state == RUN) && k_last && fifo_empty;

    // On the k=0 cycle the new word is still in flight, so forward it.
    assign x0_eff = rd_pend ? x1 : x0;
    assign x1_eff = rd_pend ? fifo_dout : x1;

    interp_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .INTERP_LOG2(INTERP_LOG2)
    ) u_mac (
        .x0(x0_eff),
        .x1(x1_eff),
        .k (k),
        .y (y)
    );

    assign y_next = (state == RUN) ? y : x1;

    // Sequencer: sample capture, phase counter and FILL/RUN/STALL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            x0       <= '0;
            x1       <= '0;
            k        <= '0;
            rd_pend  <= 1'b0;
            fill_one <= 1'b0;
        end else begin
            rd_pend <= fifo_rd_en;
            if (rd_pend) begin
                x0 <= x1;
                x1 <= fifo_dout;
            end
            unique case (state)
                FILL: begin
                    if (rd_pend) begin
                        if (fill_one) begin
                            state    <= RUN;
                            k        <= '0;
                            fill_one <= 1'b0;
                        end else begin
                            fill_one <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    k <= k + INTERP_LOG2'(1);
                    if (under_set) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (rd_pend) begin
                        state <= RUN;
                        k     <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Output registers: sample, valid flag and offset-binary DAC code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inter_data  <= '0;
            inter_valid <= 1'b0;
            da_code     <= DA_OFFSET;
        end else begin
            inter_data  <= y_next;
            inter_valid <= (state == RUN);
            da_code     <= y_next[DATA_WIDTH-1:DATA_WIDTH-8] + DA_OFFSET;
        end
    end

    // Sticky underrun flag; a new event beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (under_set) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lin_interpolation.sv
// Directed bench for lin_interpolation (L=4, 12-bit).
// Small FIFO model with one-cycle read latency feeds the DUT.
module tb_lin_interpolation;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [11:0] fifo_dout = '0;
    logic               fifo_empty;
    logic               fifo_rd_en;
    logic signed [11:0] inter_data;
    logic               inter_valid;
    logic [7:0]         da_code;
    logic               underrun;
    logic               underrun_clr = 1'b0;

    logic [11:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int rd_base;

    lin_interpolation #(
        .DATA_WIDTH (12),
        .INTERP_LOG2(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .inter_data  (inter_data),
        .inter_valid (inter_valid),
        .da_code     (da_code),
        .underrun    (underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
            rd_cnt    <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int v);
        mem[wr_ptr] = 12'(v);
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        underrun_clr = 1'b0;
        @(negedge clk);
        check("rst_data", int'(inter_data), 0);
        check("rst_valid", int'(inter_valid), 0);
        check("rst_da", int'(da_code), 128);
        check("rst_underrun", int'(underrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!inter_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(inter_valid), 1);
    endtask

    initial begin
        // Ramp 0 -> 400 -> 800, then underrun and resume.
        do_reset();
        push(0);
        push(400);
        push(800);
        wait_valid("fill_valid");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ramp%0d", i), int'(inter_data), i * 100);
            check($sformatf("ramp_v%0d", i), int'(inter_valid), 1);
            @(negedge clk);
        end
        check("stall_valid", int'(inter_valid), 0);
        check("stall_hold", int'(inter_data), 800);
        check("stall_underrun", int'(underrun), 1);
        push(1200);
        wait_valid("resume_valid");
        check("resume_k0", int'(inter_data), 800);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("clr_underrun", int'(underrun), 0);
        check("resume_k1", int'(inter_data), 900);
        @(negedge clk);
        check("resume_k2", int'(inter_data), 1000);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("resume_k3", int'(inter_data), 1100);
        check("set_wins", int'(underrun), 1);

        // Floor rounding on a negative step.
        do_reset();
        push(0);
        push(-3);
        wait_valid("neg_valid");
        check("neg0", int'(inter_data), 0);
        @(negedge clk);
        check("neg1", int'(inter_data), -1);
        check("neg1_da", int'(da_code), 8'h7F);
        @(negedge clk);
        check("neg2", int'(inter_data), -2);
        @(negedge clk);
        check("neg3", int'(inter_data), -3);

        // DAC code extremes.
        do_reset();
        repeat (3) push(12'h7FF);
        wait_valid("max_valid");
        check("max_data", int'(inter_data), 2047);
        check("max_da", int'(da_code), 8'hFF);
        repeat (12) @(negedge clk);
        do_reset();
        repeat (3) push(-2048);
        wait_valid("min_valid");
        check("min_data", int'(inter_data), -2048);
        check("min_da", int'(da_code), 8'h00);
        repeat (12) @(negedge clk);

        // Reset while a capture is pending drops that word.
        do_reset();
        push(0);
        push(400);
        push(800);
        wait_valid("pre_valid");
        repeat (3) @(negedge clk);
        check("pre_k3", int'(inter_data), 300);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", int'(inter_data), 0);
        check("mid_rst_valid", int'(inter_valid), 0);
        check("mid_rst_da", int'(da_code), 128);
        check("mid_rst_underrun", int'(underrun), 0);
        @(negedge clk);
        rd_base = rd_cnt;
        rst_n = 1'b1;
        push(1000);
        push(2000);
        wait_valid("refill_valid");
        check("refill_first", int'(inter_data), 1000);
        check("refill_reads", rd_cnt - rd_base, 2);
        @(negedge clk);
        check("refill_k1", int'(inter_data), 1250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lin_interpolation.md
LIN_INTERPOLATION -- requirements
Module: lin_interpolation

Interface
REQ-001 Parameter DATA_WIDTH, default 12: sample width, signed two's complement.
REQ-002 Parameter INTERP_LOG2, default 2: interpolation factor L = 2^INTERP_LOG2; legal range 1..4.
REQ-003 clk  in  1: single clock domain (AD_Local_CLK); all logic on rising edge.
REQ-004 rst_n  in  1: asynchronous assert, active-low reset.
REQ-005 fifo_dout  in  DATA_WIDTH: demodulated sample from output FIFO; standard read mode, valid one cycle after fifo_rd_en.
REQ-006 fifo_empty  in  1: output FIFO empty flag.
REQ-007 fifo_rd_en  out  1: FIFO read strobe; combinational from state and fifo_empty.
REQ-008 inter_data  out  DATA_WIDTH: signed, registered, interpolated sample at clk rate.
REQ-009 inter_valid  out  1: registered; high when inter_data is an interpolated RUN-state value.
REQ-010 da_code  out  8: registered offset-binary DAC code = inter_data[DATA_WIDTH-1:DATA_WIDTH-8] + 8'h80, mod 256.
REQ-011 underrun  out  1: sticky FIFO-underrun flag.
REQ-012 underrun_clr  in  1: synchronous clear of underrun.

Function
REQ-013 States SHALL be FILL, RUN, STALL; internal regs x0, x1 (DATA_WIDTH), phase k (INTERP_LOG2 bits), rd_pend (1).
REQ-014 fifo_rd_en SHALL = !fifo_empty && !rd_pend && (state==FILL || state==STALL || (state==RUN && k==L-1)); rd_pend is fifo_rd_en delayed one cycle.
REQ-015 Each cycle with rd_pend=1, capture: x0<=x1, x1<=fifo_dout.
REQ-016 FILL: after second capture since reset, go RUN with k=0.
REQ-017 RUN: k increments by 1 per cycle, wrapping L-1 -> 0; the capture lands on the cycle k wraps to 0, giving gap-free output.
REQ-018 RUN, k==L-1, fifo_empty=1: go STALL next cycle; set underrun.
REQ-019 STALL: read when non-empty; on capture go RUN with k=0.
REQ-020 Interpolation: y = x0 + ((x1-x0)*k >>> INTERP_LOG2); difference DATA_WIDTH+1 bits, product DATA_WIDTH+1+INTERP_LOG2 bits, arithmetic shift (floor toward -inf), result truncated to DATA_WIDTH, never overflows.
REQ-021 inter_data SHALL register y of the current x0/x1/k: one-cycle latency; inter_valid=1 iff previous-cycle state was RUN.
REQ-022 In FILL/STALL, inter_data SHALL hold x1 (last sample, zero-order hold) and inter_valid=0.
REQ-023 da_code SHALL update on the same edge as inter_data, from the same y.
REQ-024 underrun_clr and a new underrun event in the same cycle: set wins.

Reset
REQ-025 rst_n low SHALL asynchronously force state=FILL, x0=x1=0, k=0, rd_pend=0, inter_data=0, inter_valid=0, da_code=8'h80, underrun=0.
REQ-026 Reset mid-RUN SHALL discard a pending FIFO capture; after release, refill from FILL.

Structure
REQ-027 Shared package interp_pkg SHALL hold the state encoding, DA offset constant 8'h80 and default INTERP_LOG2.
REQ-028 One sub-module interp_mac (pure combinational x0, x1, k -> y per REQ-020) SHALL be instantiated once.

Verification (L=4, DATA_WIDTH=12)
REQ-029 FIFO holds 0, 400, 800 -> after fill, inter_data = 0,100,200,300,400,500,600,700 with inter_valid=1 and no gap.
REQ-030 Samples 0, -3 -> inter_data = 0,-1,-2,-3 (floor rounding).
REQ-031 Constant 0x7FF -> da_code 8'hFF; constant 0x800 -> 8'h00; reset -> 8'h80.
REQ-032 FIFO runs empty at k=3 -> underrun=1, inter_valid=0, inter_data held at x1; one write -> RUN resumes at k=0; underrun_clr -> 0.
REQ-033 rst_n pulsed low mid-RUN with rd_pend=1 -> all outputs at reset values immediately; capture dropped; two new reads before inter_valid.
REQ-034 underrun_clr asserted in the same cycle as a new underrun -> underrun stays 1.
